serial_alu: RTL and testbench
=============================

# serial_alu

Multi-cycle, parametrised ALU that processes a WIDTH-bit operand pair SLICE_W bits per clock, least-significant slice first, with carry/borrow rippled through a register between cycles. It is the word-level successor to the single-bit ALU slice and supports the same four operations (AND, OR, ADD, SUB), adding a carry-in/borrow-in, a valid/ready handshake on both sides, and NZCV status flags. It sits between the operand/register-read logic and writeback, trading latency for area.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of SLICE_W
- SLICE_W, 4, bits processed per RUN cycle; 1 ≤ SLICE_W ≤ WIDTH
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operands/op valid
- in_ready  out  1  block can accept; high iff state is IDLE
- op  in  2  00 AND, 01 OR, 10 ADD, 11 SUB
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  ADD: carry-in; SUB: borrow-in; ignored for logic ops
- out_valid  out  1  result and flags valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- flag_n  out  1  result[WIDTH-1]
- flag_z  out  1  result == 0
- flag_c  out  1  final adder carry-out; SUB: 1 = no borrow; 0 for logic ops
- flag_v  out  1  signed overflow (carry into MSB xor carry out of MSB); 0 for logic ops

## Operation
- N = WIDTH/SLICE_W slices. States: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid: latch op, a, b; slice counter ← 0; carry register ← cin (ADD) or ~cin (SUB); → RUN.
- RUN: per cycle apply the slice function to the low SLICE_W bits of the A/B shift registers with the carry register; shift A/B right by SLICE_W; shift the slice output into result from the top; update carry; counter++. After slice N-1 → DONE.
- SUB: B slice inverted before the adder, so a − b − cin = a + ~b + ~cin.
- Logic ops: carry register unused; flag_c=flag_v=0.
- flag_v captured from the last slice: carry into its MSB xor its carry-out.
- DONE: out_valid=1; result/flags held stable. On out_ready → IDLE.
- Inputs outside the IDLE accept cycle are ignored; op/a/b/cin may change freely during RUN/DONE.

## Timing
- Accept in cycle T (in_valid & in_ready). RUN during T+1..T+N. out_valid first high in T+N+1 (latency N+1). Minimum issue interval N+2 (IDLE cycle between operations; no accept during DONE).
- out_ready held low: remain in DONE indefinitely, outputs unchanged.
- out_ready already high on the first DONE cycle: one-cycle DONE, IDLE next.
- Reset (any state, any cycle): state IDLE, counter 0, carry 0, result 0, all flags 0, out_valid 0, in_ready 1. An in-flight operation is discarded; no partial result ever appears.
- SLICE_W = WIDTH: single RUN cycle, latency 2.
- All outputs registered except in_ready (decoded from state).

## Structure
- Shared package: op encoding constants (OP_AND, OP_OR, OP_ADD, OP_SUB) and the state enum.
- Sub-module alu_slice_n: combinational SLICE_W-wide slice (op, a, b, cin → o, cout, c_msb), built from the existing full-adder and per-bit logic; instantiated once.
- Top holds FSM, counter (width clog2(N), min 1), shift registers, carry and flag registers.

## Test plan
Default WIDTH=16, SLICE_W=4 (N=4) unless stated.
- ADD 0x1234 + 0x0FFF, cin=0 → result 0x2233, NZCV=0000; out_valid exactly 5 cycles after accept; in_ready low throughout.
- SUB 0x0005 − 0x0007, cin=0 → 0xFFFE, N=1 Z=0 C=0 V=0; SUB 0x0007 − 0x0005, cin=1 → 0x0001, C=1.
- ADD 0x7FFF + 0x0001 → 0x8000, N=1 V=1 C=0; ADD 0xFFFF + 0x0001 → 0x0000, Z=1 C=1 V=0.
- AND 0xF0F0 & 0x3C3C → 0x3030; OR → 0xFCFC; C=V=0 even with cin=1.
- out_ready low 3 cycles in DONE with in_valid high and new operands driven → result/flags stable, in_ready 0, nothing accepted; releases on out_ready, next op accepted from IDLE.
- rst_n pulsed low in second RUN cycle → out_valid 0, result 0, in_ready 1 immediately; following ADD 0x0001 + 0x0001 → 0x0002. Repeat ADD vector set with SLICE_W=1 and SLICE_W=16 (latency 17 and 2).

Source files
------------

// File: rtl/serial_alu_pkg.sv
// Shared definitions for the bit-serial ALU: op encoding, FSM states, op helpers.
package serial_alu_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_AND = 2'b00;
    localparam op_t OP_OR  = 2'b01;
    localparam op_t OP_ADD = 2'b10;
    localparam op_t OP_SUB = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    // Arithmetic ops are the ones with the top encoding bit set.
    function automatic logic is_arith(input op_t op);
        return op[1];
    endfunction

endpackage

// File: rtl/serial_alu_if.sv
// Operand/result handshake bundle between register-read, the serial ALU and writeback.
interface serial_alu_if #(
    parameter int WIDTH = 16
);
    import serial_alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    op_t              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, op, a, b, cin, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );

    modport slave (
        input  in_valid, op, a, b, cin, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );

endinterface

// File: rtl/alu_slice_n.sv
// Purpose: combinational SLICE_W-bit ALU slice (AND/OR/ADD/SUB) with ripple carry.
// Latency: 0 cycles, purely combinational.
// Backpressure: none; the enclosing FSM decides when the outputs are consumed.
module alu_slice_n
    import serial_alu_pkg::*;
#(
    parameter int SLICE_W = 4
) (
    input  op_t                op,
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] o,
    output logic               cout,
    output logic               c_msb
);

    logic [SLICE_W-1:0] bx;
    logic [SLICE_W-1:0] sum;
    logic [SLICE_W:0]   c;

    always_comb begin
        bx   = (op == OP_SUB) ? ~b : b;
        sum  = '0;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < SLICE_W; i++) begin
            sum[i]   = a[i] ^ bx[i] ^ c[i];
            c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
        end
        case (op)
            OP_AND:  o = a & b;
            OP_OR:   o = a | b;
            default: o = sum;
        endcase
    end

    assign cout  = c[SLICE_W];
    assign c_msb = c[SLICE_W-1];

endmodule

// File: rtl/serial_alu.sv
// Purpose: WIDTH-bit ALU evaluated SLICE_W bits per cycle, LSB slice first, with NZCV flags.
// Latency: WIDTH/SLICE_W + 1 cycles from accept to out_valid; one IDLE cycle between ops.
// Backpressure: holds result/flags in DONE until out_ready; accepts only while IDLE.
module serial_alu
    import serial_alu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SLICE_W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    serial_alu_if.slave  bus
);

    localparam int N  = WIDTH / SLICE_W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_t             state_q, state_d;
    op_t                op_q;
    logic [WIDTH-1:0]   a_sr, b_sr, res_q, res_d;
    logic [CW-1:0]      cnt_q;
    logic               carry_q;
    logic               out_valid_q;
    logic               n_q, z_q, c_q, v_q;
    logic [SLICE_W-1:0] s_o;
    logic               s_cout, s_cmsb;
    logic               accept, last;

    assign accept = bus.in_valid && (state_q == S_IDLE);
    assign last   = (cnt_q == CW'(N - 1));

    alu_slice_n #(.SLICE_W(SLICE_W)) u_slice (
        .op    (op_q),
        .a     (a_sr[SLICE_W-1:0]),
        .b     (b_sr[SLICE_W-1:0]),
        .cin   (carry_q),
        .o     (s_o),
        .cout  (s_cout),
        .c_msb (s_cmsb)
    );

    // New slice enters at the top so the LSB slice ends up at bit 0 after N shifts.
    assign res_d = (res_q >> SLICE_W) | (WIDTH'(s_o) << (WIDTH - SLICE_W));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= OP_AND;
            a_sr        <= '0;
            b_sr        <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            n_q         <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
            v_q         <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        op_q    <= bus.op;
                        a_sr    <= bus.a;
                        b_sr    <= bus.b;
                        cnt_q   <= '0;
                        // SUB runs as a + ~b + ~cin, so borrow-in enters inverted.
                        carry_q <= (bus.op == OP_SUB) ? ~bus.cin : bus.cin;
                    end
                end
                S_RUN: begin
                    a_sr    <= a_sr >> SLICE_W;
                    b_sr    <= b_sr >> SLICE_W;
                    res_q   <= res_d;
                    carry_q <= s_cout;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        out_valid_q <= 1'b1;
                        n_q         <= res_d[WIDTH-1];
                        z_q         <= (res_d == '0);
                        c_q         <= is_arith(op_q) & s_cout;
                        v_q         <= is_arith(op_q) & (s_cmsb ^ s_cout);
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) out_valid_q <= 1'b0;
                end
                default: out_valid_q <= 1'b0;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = res_q;
    assign bus.flag_n    = n_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
    assign bus.flag_v    = v_q;

endmodule

// File: tb/tb_serial_alu.sv
// Directed, table-driven bench for serial_alu at SLICE_W = 1, 4 and 16 (WIDTH = 16).
module tb_serial_alu;
    import serial_alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        in_valid_s  = 1'b0;
    op_t         op_s        = OP_AND;
    logic [15:0] a_s         = '0;
    logic [15:0] b_s         = '0;
    logic        cin_s       = 1'b0;
    logic        out_ready_s = 1'b1;
    int          sel         = 4;

    serial_alu_if #(.WIDTH(16)) if1 ();
    serial_alu_if #(.WIDTH(16)) if4 ();
    serial_alu_if #(.WIDTH(16)) if16 ();

    assign if1.in_valid  = in_valid_s && (sel == 1);
    assign if4.in_valid  = in_valid_s && (sel == 4);
    assign if16.in_valid = in_valid_s && (sel == 16);
    assign if1.out_ready  = (sel == 1)  ? out_ready_s : 1'b1;
    assign if4.out_ready  = (sel == 4)  ? out_ready_s : 1'b1;
    assign if16.out_ready = (sel == 16) ? out_ready_s : 1'b1;
    assign if1.op  = op_s;  assign if1.a  = a_s; assign if1.b  = b_s; assign if1.cin  = cin_s;
    assign if4.op  = op_s;  assign if4.a  = a_s; assign if4.b  = b_s; assign if4.cin  = cin_s;
    assign if16.op = op_s;  assign if16.a = a_s; assign if16.b = b_s; assign if16.cin = cin_s;

    serial_alu #(.WIDTH(16), .SLICE_W(1))  u_w1  (.clk(clk), .rst_n(rst_n), .bus(if1));
    serial_alu #(.WIDTH(16), .SLICE_W(4))  u_w4  (.clk(clk), .rst_n(rst_n), .bus(if4));
    serial_alu #(.WIDTH(16), .SLICE_W(16)) u_w16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    logic        ob_in_ready, ob_out_valid;
    logic [15:0] ob_result;
    logic [3:0]  ob_nzcv;

    always_comb begin
        ob_in_ready  = if4.in_ready;
        ob_out_valid = if4.out_valid;
        ob_result    = if4.result;
        ob_nzcv      = {if4.flag_n, if4.flag_z, if4.flag_c, if4.flag_v};
        if (sel == 1) begin
            ob_in_ready  = if1.in_ready;
            ob_out_valid = if1.out_valid;
            ob_result    = if1.result;
            ob_nzcv      = {if1.flag_n, if1.flag_z, if1.flag_c, if1.flag_v};
        end else if (sel == 16) begin
            ob_in_ready  = if16.in_ready;
            ob_out_valid = if16.out_valid;
            ob_result    = if16.result;
            ob_nzcv      = {if16.flag_n, if16.flag_z, if16.flag_c, if16.flag_v};
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s w%0d actual=%0h expected=%0h", nm, sel, act, exp);
        end
    endtask

    // Issue one op on the selected DUT and check latency, busy, result and NZCV.
    task automatic run_op(input string nm, input op_t o, input logic [15:0] a,
                          input logic [15:0] b, input logic c, input logic [15:0] er,
                          input logic [3:0] ef, input int elat);
        int k;
        logic busy_err;
        @(negedge clk);
        op_s = o; a_s = a; b_s = b; cin_s = c; in_valid_s = 1'b1;
        k = 0;
        while (!ob_in_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_accept_rdy"}, 32'(ob_in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        op_s = ~o; a_s = ~a; b_s = ~b; cin_s = ~c;
        busy_err = 1'b0;
        k = 1;
        while (k <= 40 && !ob_out_valid) begin
            if (ob_in_ready) busy_err = 1'b1;
            @(posedge clk); #1;
            k++;
        end
        check({nm, "_latency"}, 32'(k), 32'(elat));
        check({nm, "_busy"}, 32'(busy_err | ob_in_ready), 32'd0);
        check({nm, "_result"}, 32'(ob_result), 32'(er));
        check({nm, "_nzcv"}, 32'(ob_nzcv), 32'(ef));
    endtask

    typedef struct {
        string       nm;
        op_t         op;
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] res;
        logic [3:0]  nzcv;
    } vec_t;

    vec_t vecs[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{"add_basic",   OP_ADD, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 4'b0000};
        vecs[1]  = '{"sub_neg",     OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 4'b1000};
        vecs[2]  = '{"sub_borrow",  OP_SUB, 16'h0007, 16'h0005, 1'b1, 16'h0001, 4'b0010};
        vecs[3]  = '{"add_ovf",     OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 4'b1001};
        vecs[4]  = '{"add_wrap",    OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 4'b0110};
        vecs[5]  = '{"and_cin",     OP_AND, 16'hF0F0, 16'h3C3C, 1'b1, 16'h3030, 4'b0000};
        vecs[6]  = '{"or_cin",      OP_OR,  16'hF0F0, 16'h3C3C, 1'b1, 16'hFCFC, 4'b1000};
        vecs[7]  = '{"add_cin",     OP_ADD, 16'h0001, 16'h0001, 1'b1, 16'h0003, 4'b0000};
        vecs[8]  = '{"sub_ovf",     OP_SUB, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 4'b0011};
        vecs[9]  = '{"sub_zero",    OP_SUB, 16'h0000, 16'h0000, 1'b0, 16'h0000, 4'b0110};
        vecs[10] = '{"and_zero",    OP_AND, 16'hFFFF, 16'h0000, 1'b0, 16'h0000, 4'b0100};

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[i]) begin end
        for (int s = 0; s < 3; s++) begin
            sel = (s == 0) ? 1 : (s == 1) ? 4 : 16;
            #1;
            check("rst_in_ready", 32'(ob_in_ready), 32'd1);
            check("rst_out_valid", 32'(ob_out_valid), 32'd0);
            check("rst_result", 32'(ob_result), 32'd0);
            check("rst_nzcv", 32'(ob_nzcv), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        for (int s = 0; s < 3; s++) begin
            sel = (s == 0) ? 4 : (s == 1) ? 1 : 16;
            for (int i = 0; i < 11; i++)
                run_op(vecs[i].nm, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
                       vecs[i].res, vecs[i].nzcv, 16 / sel + 1);
        end

        // Stall in DONE while new operands are offered; they must be ignored.
        sel = 4;
        out_ready_s = 1'b0;
        run_op("stall_add", OP_ADD, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 4'b0000, 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid_s = 1'b1; op_s = OP_SUB; a_s = 16'hFFFF; b_s = 16'h0001; cin_s = 1'b1;
            @(posedge clk); #1;
            check("stall_valid", 32'(ob_out_valid), 32'd1);
            check("stall_in_ready", 32'(ob_in_ready), 32'd0);
            check("stall_result", 32'(ob_result), 32'h2233);
            check("stall_nzcv", 32'(ob_nzcv), 32'd0);
        end
        @(negedge clk);
        out_ready_s = 1'b1;
        op_s = OP_AND; a_s = 16'hF0F0; b_s = 16'h3C3C; cin_s = 1'b0;
        @(posedge clk); #1;
        check("release_in_ready", 32'(ob_in_ready), 32'd1);
        check("release_out_valid", 32'(ob_out_valid), 32'd0);
        run_op("after_stall_and", OP_AND, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 4'b0000, 5);

        // Reset pulsed in the second RUN cycle discards the op and clears all state.
        run_op("pre_rst_sub", OP_SUB, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 4'b1000, 5);
        @(negedge clk);
        op_s = OP_ADD; a_s = 16'hFFFF; b_s = 16'hFFFF; cin_s = 1'b0; in_valid_s = 1'b1;
        @(posedge clk); #1;
        in_valid_s = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 32'(ob_out_valid), 32'd0);
        check("midrun_rst_result", 32'(ob_result), 32'd0);
        check("midrun_rst_in_ready", 32'(ob_in_ready), 32'd1);
        check("midrun_rst_nzcv", 32'(ob_nzcv), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst_add", OP_ADD, 16'h0001, 16'h0001, 1'b0, 16'h0002, 4'b0000, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
